// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
// owner_t records which requester the next-cycle response belongs to.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int STARVE_W   = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch (IF) and load/store (DM): DM wins by default,
// but IF is forced through after STARVE_MAX consecutive losses.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req_i,
  input  logic dm_req_i,
  output logic if_gnt_o,
  output logic dm_gnt_o
);

  localparam logic [STARVE_W-1:0] SMAX = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                if_forced;

  always_comb begin
    if_forced = if_req_i && dm_req_i && (starve_q == SMAX);
    dm_gnt_o  = !reset && dm_req_i && !if_forced;
    if_gnt_o  = !reset && if_req_i && (!dm_req_i || if_forced);

    // Counts only cycles where IF is actively waiting behind DM.
    starve_d = starve_q;
    if (!if_req_i || if_gnt_o) begin
      starve_d = '0;
    end else if (dm_gnt_o && (starve_q != SMAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port memory between IF and DM: one grant per
// cycle, address/write muxing, and routing of the 1-cycle-late response.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_owner_o
);

  // Handshake: a request is held stable with req=1 until its gnt is seen in the
  // same cycle; the matching rvalid follows exactly one cycle later, no stalls.

  owner_t owner_q, owner_d;
  logic   err_q, err_d;
  logic   we_q, we_d;
  logic   if_mis, dm_mis;

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .reset    (reset),
    .if_req_i (if_req),
    .dm_req_i (dm_req),
    .if_gnt_o (if_gnt),
    .dm_gnt_o (dm_gnt)
  );

  always_comb begin
    if_mis    = (if_addr[1:0] != 2'b00);
    dm_mis    = (dm_addr[1:0] != 2'b00);
    mem_addr  = dm_gnt ? dm_addr : if_addr;
    mem_wdata = dm_wdata;
    // Misaligned accesses are granted and answered with an error, never issued.
    mem_en    = (dm_gnt && !dm_mis) || (if_gnt && !if_mis);
    mem_we    = dm_gnt && !dm_mis && dm_we;

    owner_d = OWN_NONE;
    err_d   = 1'b0;
    we_d    = 1'b0;
    if (dm_gnt) begin
      owner_d = OWN_DM;
      err_d   = dm_mis;
      we_d    = dm_we;
    end else if (if_gnt) begin
      owner_d = OWN_IF;
      err_d   = if_mis;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    if_rvalid   = (owner_q == OWN_IF);
    dm_rvalid   = (owner_q == OWN_DM);
    if_err      = if_rvalid && err_q;
    dm_err      = dm_rvalid && err_q;
    if_rdata    = (if_rvalid && !err_q) ? mem_rdata : '0;
    dm_rdata    = (dm_rvalid && !err_q && !we_q) ? mem_rdata : '0;
    dbg_owner_o = owner_q;
  end

endmodule
